// File: rtl/fm_demod_pkg.sv
// fm_demod_pkg: shared types and helpers for the FM discriminator core.
//   - mac_state_e   : MAC sequencer states (IDLE, MAC, DONE)
//   - acc_w()       : accumulator width that cannot overflow for a given FIR
//   - default_coef(): default symmetric 21-tap low-pass coefficients
//                     (sum 2971); indices past the table read as zero.
// Optional feature macro used by the core: FM_DEMOD_DEEMPH_EN.
package fm_demod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Worst case is every tap and coefficient at full scale summed TAPS times.
  function automatic int acc_w(input int out_w, input int coef_w, input int taps);
    return out_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic [15:0] default_coef(input int unsigned k);
    logic [15:0] c;
    case (k)
      32'd0:   c = 16'h011;
      32'd1:   c = 16'h022;
      32'd2:   c = 16'h039;
      32'd3:   c = 16'h055;
      32'd4:   c = 16'h076;
      32'd5:   c = 16'h098;
      32'd6:   c = 16'h0b9;
      32'd7:   c = 16'h0d7;
      32'd8:   c = 16'h0ef;
      32'd9:   c = 16'h0fe;
      32'd10:  c = 16'h103;
      32'd11:  c = 16'h0fe;
      32'd12:  c = 16'h0ef;
      32'd13:  c = 16'h0d7;
      32'd14:  c = 16'h0b9;
      32'd15:  c = 16'h098;
      32'd16:  c = 16'h076;
      32'd17:  c = 16'h055;
      32'd18:  c = 16'h039;
      32'd19:  c = 16'h022;
      32'd20:  c = 16'h011;
      default: c = 16'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fm_fir_mac.sv
// fm_fir_mac: time-multiplexed single-MAC FIR with saturating output.
// On 'start' it walks taps[0..TAPS-1] against the coefficients, one product
// per cycle, then presents min(acc >> OUT_SHIFT, 2^OUT_W-1) for one cycle.
// Ports:
//   clk_fm_demo_sampling : clock
//   RSTn                 : asynchronous active-low reset
//   demod_en             : low aborts any sweep (no output) and idles the FSM
//   start                : trigger push happening this cycle
//   taps                 : delay line, taps[0] is the newest sample
//   fir_out / fir_valid  : saturated result and its one-cycle strobe (DONE)
//   mac_hold             : the sweep is still running in the next cycle
module fm_fir_mac
  import fm_demod_pkg::*;
#(
  parameter int OUT_W     = 10,
  parameter int TAPS      = 21,
  parameter int COEF_W    = 9,
  parameter int OUT_SHIFT = 12
) (
  input  logic                       clk_fm_demo_sampling,
  input  logic                       RSTn,
  input  logic                       demod_en,
  input  logic                       start,
  input  logic [TAPS-1:0][OUT_W-1:0] taps,
  output logic [OUT_W-1:0]           fir_out,
  output logic                       fir_valid,
  output logic                       mac_hold
);

  localparam int ACC_W = acc_w(OUT_W, COEF_W, TAPS);
  localparam int KW    = $clog2(TAPS);
  localparam logic [KW-1:0]    K_LAST  = KW'(TAPS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  mac_state_e       state_r;
  mac_state_e       state_next;
  logic [KW-1:0]    k_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_sum_s;
  logic [ACC_W-1:0] shifted_s;
  logic [COEF_W-1:0] coef_s;
  logic             last_s;

  // Datapath for the current MAC step, including the final shifted value.
  always_comb begin
    coef_s    = COEF_W'(default_coef(32'(k_r)));
    acc_sum_s = acc_r + ACC_W'(taps[k_r]) * ACC_W'(coef_s);
    shifted_s = acc_sum_s >> OUT_SHIFT;
    last_s    = (k_r == K_LAST);
  end

  // Next-state logic; demod_en low forces IDLE from any state.
  always_comb begin
    state_next = state_r;
    mac_hold   = 1'b0;
    if (!demod_en) begin
      state_next = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) state_next = MAC;
          else       state_next = IDLE;
        end
        MAC: begin
          if (last_s) begin
            state_next = DONE;
          end else begin
            state_next = MAC;
            mac_hold   = 1'b1;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) state_r <= IDLE;
    else       state_r <= state_next;
  end

  // Accumulator, tap index and registered saturated result.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      k_r       <= '0;
      acc_r     <= '0;
      fir_out   <= '0;
      fir_valid <= 1'b0;
    end else begin
      fir_valid <= 1'b0;
      if (state_r == IDLE && state_next == MAC) begin
        acc_r <= '0;
        k_r   <= '0;
      end else if (state_r == MAC && demod_en) begin
        acc_r <= acc_sum_s;
        k_r   <= k_r + KW'(1);
        // The last product lands straight in the output so DONE shows it.
        if (last_s) begin
          fir_out   <= (shifted_s > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(shifted_s);
          fir_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fm_demod_core.sv
// fm_demod_core: FM cross-product discriminator feeding a decimating FIR.
// Accepted I/Q pairs form d = I1*Q0 - Q1*I0 + 2^(2*IN_W); its top OUT_W bits
// are pushed into a TAPS-deep delay line two cycles after acceptance. Every
// DECIM-th push starts one FIR sweep in fm_fir_mac; the result appears
// TAPS+3 cycles after the triggering pair.
// Macro FM_DEMOD_DEEMPH_EN: adds a first-order de-emphasis stage
//   y <= y + ((x - y) >>> DEEMPH_SHIFT) after the FIR (latency TAPS+4).
// Ports:
//   clk_fm_demo_sampling : clock
//   RSTn                 : asynchronous active-low reset
//   demod_en             : enable; low idles the block, clears counter/overrun
//   iq_valid, i_data, q_data : unsigned I/Q pair strobe and samples
//   sample_out, sample_valid : audio sample and its one-cycle strobe
//   busy                 : a sweep is pending or running; pairs are refused
//   overrun              : sticky, a pair arrived while busy
module fm_demod_core
  import fm_demod_pkg::*;
#(
  parameter int IN_W         = 8,
  parameter int OUT_W        = 10,
  parameter int TAPS         = 21,
  parameter int COEF_W       = 9,
  parameter int DECIM        = 2,
  parameter int OUT_SHIFT    = 12,
  parameter int DEEMPH_SHIFT = 3
) (
  input  logic             clk_fm_demo_sampling,
  input  logic             RSTn,
  input  logic             demod_en,
  input  logic             iq_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic [IN_W-1:0]  q_data,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int DW = 2 * IN_W + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DECIM - 1);
  localparam logic [OUT_W-1:0] MID      = OUT_W'(32'd1 << (OUT_W - 1));
  localparam logic [DW-1:0]    D_BIAS   = {1'b1, {(2 * IN_W){1'b0}}};

  logic [IN_W-1:0]            i0_r, q0_r, i1_r, q1_r;
  logic                       v0_r, t0_r, v1_r, t1_r;
  logic [OUT_W-1:0]           tap_r;
  logic [TAPS-1:0][OUT_W-1:0] line_r;
  logic [CW-1:0]              cnt_r;
  logic                       busy_r;
  logic                       overrun_r;

  logic                       accept_s;
  logic                       trig_s;
  logic [DW-1:0]              d_s;
  logic [OUT_W-1:0]           tap_s;
  logic                       busy_next_s;
  logic [OUT_W-1:0]           fir_out_s;
  logic                       fir_valid_s;
  logic                       mac_hold_s;

  // Acceptance, trigger prediction and the biased discriminator.
  always_comb begin
    accept_s = iq_valid & demod_en & ~busy_r;
    // The decimation count advances on acceptance; pushes follow in order
    // two cycles later, so the trigger is known as soon as the pair arrives.
    trig_s   = (cnt_r == CNT_LAST);
    // Modulo-2^DW arithmetic is exact because the true value is in range.
    d_s      = DW'(i1_r) * DW'(q0_r) - DW'(q1_r) * DW'(i0_r) + D_BIAS;
    tap_s    = OUT_W'(d_s >> (DW - OUT_W));
    busy_next_s = demod_en & ((accept_s & trig_s) | t0_r | t1_r | mac_hold_s);
  end

  // I/Q history and the two-stage product pipeline.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      i0_r  <= '0;
      q0_r  <= '0;
      i1_r  <= '0;
      q1_r  <= '0;
      v0_r  <= 1'b0;
      t0_r  <= 1'b0;
      v1_r  <= 1'b0;
      t1_r  <= 1'b0;
      tap_r <= MID;
    end else if (!demod_en) begin
      // Pairs still in the pipeline are discarded; history is kept.
      v0_r <= 1'b0;
      t0_r <= 1'b0;
      v1_r <= 1'b0;
      t1_r <= 1'b0;
    end else begin
      v0_r <= accept_s;
      t0_r <= accept_s & trig_s;
      v1_r <= v0_r;
      t1_r <= t0_r;
      if (accept_s) begin
        i1_r <= i0_r;
        q1_r <= q0_r;
        i0_r <= i_data;
        q0_r <= q_data;
      end
      if (v0_r) tap_r <= tap_s;
    end
  end

  // Delay line; taps[0] holds the newest discriminator value.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      line_r <= {TAPS{MID}};
    end else if (demod_en && v1_r) begin
      line_r <= {line_r[TAPS-2:0], tap_r};
    end
  end

  // Decimation counter.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      cnt_r <= '0;
    end else if (!demod_en) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= trig_s ? '0 : cnt_r + CW'(1);
    end
  end

  // Registered busy and sticky overrun flags.
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      if (!demod_en)                overrun_r <= 1'b0;
      else if (iq_valid && busy_r)  overrun_r <= 1'b1;
    end
  end

  assign busy    = busy_r;
  assign overrun = overrun_r;

  fm_fir_mac #(
    .OUT_W     (OUT_W),
    .TAPS      (TAPS),
    .COEF_W    (COEF_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk_fm_demo_sampling (clk_fm_demo_sampling),
    .RSTn                 (RSTn),
    .demod_en             (demod_en),
    .start                (t1_r),
    .taps                 (line_r),
    .fir_out              (fir_out_s),
    .fir_valid            (fir_valid_s),
    .mac_hold             (mac_hold_s)
  );

`ifdef FM_DEMOD_DEEMPH_EN
  logic [OUT_W-1:0]        y_r;
  logic                    sv_r;
  logic signed [OUT_W+1:0] diff_s;

  // Signed error between the new FIR sample and the de-emphasis state.
  always_comb begin
    diff_s = $signed({2'b00, fir_out_s}) - $signed({2'b00, y_r});
  end

  // De-emphasis pole; the step never leaves [min(x,y), max(x,y)].
  always_ff @(posedge clk_fm_demo_sampling or negedge RSTn) begin
    if (!RSTn) begin
      y_r  <= MID;
      sv_r <= 1'b0;
    end else if (!demod_en) begin
      sv_r <= 1'b0;
    end else begin
      sv_r <= fir_valid_s;
      if (fir_valid_s) begin
        y_r <= OUT_W'($signed({2'b00, y_r}) + (diff_s >>> DEEMPH_SHIFT));
      end
    end
  end

  assign sample_out   = y_r;
  assign sample_valid = sv_r;
`else
  // The pole shift only matters in the de-emphasis build.
  logic [31:0] deemph_unused_s;
  assign deemph_unused_s = 32'(DEEMPH_SHIFT);

  assign sample_out   = fir_out_s;
  assign sample_valid = fir_valid_s;
`endif

endmodule

// File: tb/tb_fm_demod_core.sv
// Bench for fm_demod_core: a sample-level model (pairs -> taps -> weighted
// sum, plus busy/overrun windows in cycles) checked every cycle against a
// default instance and an OUT_SHIFT=10 instance that must saturate.
module tb_fm_demod_core;

  localparam int TAPS  = 21;
  localparam int DECIM = 2;
`ifdef FM_DEMOD_DEEMPH_EN
  localparam int LAT = TAPS + 4;
`else
  localparam int LAT = TAPS + 3;
`endif

  logic       clk_fm_demo_sampling = 1'b0;
  logic       RSTn;
  logic       demod_en;
  logic       iq_valid;
  logic [7:0] i_data;
  logic [7:0] q_data;
  logic [9:0] sample_out, sample_out_sat;
  logic       sample_valid, sample_valid_sat;
  logic       busy, busy_sat, overrun, overrun_sat;

  always #5 clk_fm_demo_sampling = ~clk_fm_demo_sampling;

  fm_demod_core dut (
    .clk_fm_demo_sampling (clk_fm_demo_sampling),
    .RSTn                 (RSTn),
    .demod_en             (demod_en),
    .iq_valid             (iq_valid),
    .i_data               (i_data),
    .q_data               (q_data),
    .sample_out           (sample_out),
    .sample_valid         (sample_valid),
    .busy                 (busy),
    .overrun              (overrun)
  );

  fm_demod_core #(.OUT_SHIFT(10)) dut_sat (
    .clk_fm_demo_sampling (clk_fm_demo_sampling),
    .RSTn                 (RSTn),
    .demod_en             (demod_en),
    .iq_valid             (iq_valid),
    .i_data               (i_data),
    .q_data               (q_data),
    .sample_out           (sample_out_sat),
    .sample_valid         (sample_valid_sat),
    .busy                 (busy_sat),
    .overrun              (overrun_sat)
  );

  int coef [TAPS] = '{17, 34, 57, 85, 118, 152, 185, 215, 239, 254, 259,
                      254, 239, 215, 185, 152, 118, 85, 57, 34, 17};

  // Model state
  int cyc;
  int line [TAPS];
  int hi0, hq0;
  int cnt, ovr;
  int out_time, out_val, out_sat;
  int busy_lo, busy_hi;
  int y, y_sat;
  int exp_out, exp_sat, exp_valid, exp_busy, exp_ovr;

  int errors, checks;
  int obs[$];
  int obs_sat[$];
  int obs_cyc[$];
  int trig_cyc;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int disc_tap(input int i1, input int q1, input int i0, input int q0);
    return (i1 * q0 - q1 * i0 + 65536) / 128;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) line[k] = 512;
    hi0 = 0; hq0 = 0; cnt = 0; ovr = 0;
    out_time = -1; out_val = 0; out_sat = 0;
    busy_lo = 1; busy_hi = 0;
    y = 512; y_sat = 512;
`ifdef FM_DEMOD_DEEMPH_EN
    exp_out = 512; exp_sat = 512;
`else
    exp_out = 0; exp_sat = 0;
`endif
    exp_valid = 0; exp_busy = 0; exp_ovr = 0;
  endtask

  // Advance the model across the clock edge that ends cycle 'cyc'.
  task automatic model_edge();
    int t, acc, n;
    if (!demod_en) begin
      if (out_time > cyc) out_time = -1;
      if (busy_hi > cyc) busy_hi = cyc;
      cnt = 0;
      ovr = 0;
    end else if (iq_valid) begin
      if (cyc >= busy_lo && cyc <= busy_hi) begin
        ovr = 1;
      end else begin
        t = disc_tap(hi0, hq0, int'(i_data), int'(q_data));
        hi0 = int'(i_data);
        hq0 = int'(q_data);
        for (int k = TAPS - 1; k > 0; k--) line[k] = line[k-1];
        line[0] = t;
        cnt++;
        if (cnt == DECIM) begin
          cnt = 0;
          acc = 0;
          for (int k = 0; k < TAPS; k++) acc += line[k] * coef[k];
          out_val  = (acc / 4096 > 1023) ? 1023 : acc / 4096;
          out_sat  = (acc / 1024 > 1023) ? 1023 : acc / 1024;
          out_time = cyc + LAT;
          busy_lo  = cyc + 1;
          busy_hi  = cyc + TAPS + 2;
        end
      end
    end
    n = cyc + 1;
    exp_valid = (out_time == n) ? 1 : 0;
    if (exp_valid == 1) begin
`ifdef FM_DEMOD_DEEMPH_EN
      y       = y + ((out_val - y) >>> 3);
      y_sat   = y_sat + ((out_sat - y_sat) >>> 3);
      exp_out = y;
      exp_sat = y_sat;
`else
      exp_out = out_val;
      exp_sat = out_sat;
`endif
    end
    exp_busy = (n >= busy_lo && n <= busy_hi) ? 1 : 0;
    exp_ovr  = ovr;
    cyc = n;
  endtask

  task automatic compare_all();
    check("sample_out", 32'(sample_out), exp_out);
    check("sample_valid", 32'(sample_valid), exp_valid);
    check("busy", 32'(busy), exp_busy);
    check("overrun", 32'(overrun), exp_ovr);
    check("sat_sample_out", 32'(sample_out_sat), exp_sat);
    check("sat_sample_valid", 32'(sample_valid_sat), exp_valid);
    if (sample_valid === 1'b1) begin
      obs.push_back(int'(sample_out));
      obs_sat.push_back(int'(sample_out_sat));
      obs_cyc.push_back(cyc);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle, then model the edge.
  task automatic step(input logic v, input int i, input int q, input logic e);
    iq_valid = v;
    i_data   = 8'(i);
    q_data   = 8'(q);
    demod_en = e;
    @(negedge clk_fm_demo_sampling);
    compare_all();
    @(posedge clk_fm_demo_sampling);
    if (RSTn) model_edge();
    else      cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 0, 0, 1'b1);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    RSTn = 1'b0; demod_en = 1'b0; iq_valid = 1'b0; i_data = 8'd0; q_data = 8'd0;
    model_reset();
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    RSTn = 1'b1;
    idle(3);

    // DC input: every second pair triggers; outputs at the settled DC level.
    obs.delete(); obs_sat.delete(); obs_cyc.delete();
    trig_cyc = -1;
    for (int p = 0; p < 42; p++) begin
      if (p == 1) trig_cyc = cyc;
      step(1'b1, 128, 128, 1'b1);
      idle(25);
    end
    check("dc_count", 32'(obs.size()), 21);
    if (obs_cyc.size() > 0) check("dc_latency", 32'(obs_cyc[0] - trig_cyc), LAT);
`ifndef FM_DEMOD_DEEMPH_EN
    foreach (obs[k]) check("dc_value", 32'(obs[k]), 371);
    foreach (obs_sat[k]) check("dc_saturated", 32'(obs_sat[k]), 1023);
`else
    if (obs.size() > 0) check("deemph_first", 32'(obs[0]), 494);
`endif

    // Impulse: (200,0) then (0,200) back to back, then return to DC.
    obs.delete(); obs_sat.delete(); obs_cyc.delete();
    step(1'b1, 200, 0, 1'b1);
    step(1'b1, 0, 200, 1'b1);
    idle(25);
    for (int p = 0; p < 4; p++) begin
      step(1'b1, 128, 128, 1'b1);
      idle(25);
    end
    check("impulse_count", 32'(obs.size()), 3);
`ifndef FM_DEMOD_DEEMPH_EN
    if (obs.size() > 2) begin
      check("impulse_0", 32'(obs[0]), 371);
      check("impulse_1", 32'(obs[1]), 369);
      check("impulse_2", 32'(obs[2]), 368);
    end
`endif

    // Directed mix: varied I/Q, back-to-back pairs and pairs while busy.
    for (int j = 0; j < 40; j++) begin
      step(1'b1, (j * 37 + 11) % 256, (j * 91 + 5) % 256, 1'b1);
      idle((j % 3 == 0) ? 0 : ((j % 3 == 1) ? 5 : 24));
    end
    idle(26);

    // Overrun: clear, trigger, hit while busy, then abort by dropping enable.
    step(1'b0, 0, 0, 1'b0);
    idle(3);
    check("ovr_cleared", 32'(overrun), 0);
    step(1'b1, 100, 30, 1'b1);
    step(1'b1, 60, 90, 1'b1);
    idle(5);
    check("ovr_busy_high", 32'(busy), 1);
    step(1'b1, 50, 60, 1'b1);
    check("ovr_set", 32'(overrun), 1);
    idle(3);
    check("ovr_held", 32'(overrun), 1);
    obs.delete();
    step(1'b0, 0, 0, 1'b0);
    check("ovr_drop_en", 32'(overrun), 0);
    check("abort_busy", 32'(busy), 0);
    // Counter reset: one pair, drop enable, next pair must not trigger.
    step(1'b1, 128, 128, 1'b1);
    idle(3);
    step(1'b0, 0, 0, 1'b0);
    idle(3);
    step(1'b1, 128, 128, 1'b1);
    idle(30);
    check("cnt_clear_no_output", 32'(obs.size()), 0);
    step(1'b1, 128, 128, 1'b1);
    idle(26);
    check("cnt_clear_trigger", 32'(obs.size()), 1);

    // Asynchronous reset mid-MAC.
    step(1'b1, 128, 128, 1'b1);
    step(1'b1, 128, 128, 1'b1);
    idle(10);
    RSTn = 1'b0;
    #1;
    check("rst_sample_out", 32'(sample_out), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_sat_out", 32'(sample_out_sat), 0);
    model_reset();
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    RSTn = 1'b1;
    obs.delete();
    idle(30);
    check("rst_no_output", 32'(obs.size()), 0);
    step(1'b1, 128, 128, 1'b1);
    step(1'b1, 128, 128, 1'b1);
    idle(26);
    check("rst_recover_count", 32'(obs.size()), 1);
`ifndef FM_DEMOD_DEEMPH_EN
    if (obs.size() > 0) check("rst_recover_value", 32'(obs[0]), 371);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
